// File: rtl/chimera_pkg.sv
// Shared types for the Chimera SoC: APB request/response structs, cluster-control
// register offsets and the cluster-control completer state encoding.
package chimera_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

    localparam logic [7:0] CluCtrlClkEnOffs = 8'h00;
    localparam logic [7:0] CluCtrlRstOffs   = 8'h04;
    localparam logic [7:0] CluCtrlBootOffs  = 8'h08;

    typedef enum logic [1:0] {
        CluCtrlIdle,
        CluCtrlWait,
        CluCtrlResp
    } clu_ctrl_state_e;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b+:8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/chimera_rst_pulse_gen.sv
// Per-cluster reset sequencer: a trigger while idle produces a reset pulse of
// exactly RstCycles cycles, starting the cycle after the trigger.
module chimera_rst_pulse_gen #(
    parameter int unsigned RstCycles = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trig_i,
    output logic busy_o,
    output logic rst_o
);

    localparam int unsigned CntWidth = $clog2(RstCycles + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                rst_q;

    // Triggers arriving while busy are dropped so a pulse can never be stretched.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            cnt_d = cnt_q - CntWidth'(1);
            if (cnt_q == CntWidth'(1)) begin
                busy_d = 1'b0;
            end
        end else if (trig_i) begin
            cnt_d  = CntWidth'(RstCycles);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            rst_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            rst_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign rst_o  = rst_q;

endmodule

// File: rtl/chimera_cluster_ctrl_apb.sv
// APB completer for cluster clock-enable, reset-pulse and boot-address control.
// Define CHIMERA_CLU_CTRL_STRB_EN to make writes honour pstrb byte enables.
module chimera_cluster_ctrl_apb
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters     = 5,
    parameter int unsigned RstCycles       = 16,
    parameter logic [31:0] BootAddrDefault = 32'h3000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  apb_req_t                    apb_req_i,
    output apb_resp_t                   apb_rsp_o,
    output logic [NumClusters-1:0]      cluster_clk_en_o,
    output logic [NumClusters-1:0]      cluster_rst_o,
    output logic [NumClusters*32-1:0]   cluster_boot_addr_o
);

    clu_ctrl_state_e state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic            write_q, write_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      strb_q, strb_d;
    logic [31:0]     prdata_q, prdata_d;
    logic            pslverr_q, pslverr_d;

    logic [NumClusters-1:0]        clk_en_q, clk_en_d;
    logic [NumClusters-1:0][31:0]  boot_q, boot_d;
    logic [NumClusters-1:0]        rst_trig, rst_busy, rst_pulse;

    logic [7:0]  boot_offs;
    logic [3:0]  boot_idx;
    logic        hit_clk_en, hit_rst, hit_boot, addr_err;
    logic [31:0] wmask, rdata, clk_en_wr, rst_req;
    logic        commit;

    // Decode always works on the latched address, never on the live bus.
    always_comb begin
        boot_offs  = addr_q - CluCtrlBootOffs;
        boot_idx   = boot_offs[5:2];
        hit_clk_en = (addr_q == CluCtrlClkEnOffs);
        hit_rst    = (addr_q == CluCtrlRstOffs);
        hit_boot   = (addr_q >= CluCtrlBootOffs) && (addr_q[1:0] == 2'b00) &&
                     (boot_offs[7:6] == 2'b00) && ({1'b0, boot_idx} < 5'(NumClusters));
        addr_err   = !(hit_clk_en || hit_rst || hit_boot);
    end

`ifdef CHIMERA_CLU_CTRL_STRB_EN
    assign wmask = strb_to_mask(strb_q);
`else
    assign wmask = '1;
`endif

    assign commit    = (state_q == CluCtrlResp) && write_q && !addr_err;
    assign clk_en_wr = ({{(32-NumClusters){1'b0}}, clk_en_q} & ~wmask) | (wdata_q & wmask);
    assign rst_req   = wdata_q & wmask;
    assign rst_trig  = (commit && hit_rst) ? rst_req[NumClusters-1:0] : '0;

    always_comb begin
        rdata = '0;
        if (hit_clk_en) begin
            rdata[NumClusters-1:0] = clk_en_q;
        end
        if (hit_rst) begin
            rdata[NumClusters-1:0] = rst_busy;
        end
        for (int i = 0; i < NumClusters; i++) begin
            if (hit_boot && (boot_idx == 4'(i))) begin
                rdata = boot_q[i];
            end
        end
    end

    // psel is not re-checked after IDLE: a dropped psel still completes the transfer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        clk_en_d  = clk_en_q;
        boot_d    = boot_q;
        case (state_q)
            CluCtrlIdle: begin
                if (apb_req_i.psel && apb_req_i.penable) begin
                    state_d = CluCtrlWait;
                    addr_d  = apb_req_i.paddr[7:0];
                    write_d = apb_req_i.pwrite;
                    wdata_d = apb_req_i.pwdata;
                    strb_d  = apb_req_i.pstrb;
                end
            end
            CluCtrlWait: begin
                state_d   = CluCtrlResp;
                prdata_d  = addr_err ? 32'h0 : rdata;
                pslverr_d = addr_err;
            end
            CluCtrlResp: begin
                state_d = CluCtrlIdle;
                if (commit && hit_clk_en) begin
                    clk_en_d = clk_en_wr[NumClusters-1:0];
                end
                for (int i = 0; i < NumClusters; i++) begin
                    if (commit && hit_boot && (boot_idx == 4'(i))) begin
                        boot_d[i] = (boot_q[i] & ~wmask) | (wdata_q & wmask);
                    end
                end
            end
            default: state_d = CluCtrlIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CluCtrlIdle;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            clk_en_q  <= '0;
            boot_q    <= {NumClusters{BootAddrDefault}};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            clk_en_q  <= clk_en_d;
            boot_q    <= boot_d;
        end
    end

    for (genvar i = 0; i < NumClusters; i++) begin : g_rst
        chimera_rst_pulse_gen #(
            .RstCycles(RstCycles)
        ) u_rst_pulse (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .trig_i (rst_trig[i]),
            .busy_o (rst_busy[i]),
            .rst_o  (rst_pulse[i])
        );
    end

    // Clock is forced on while a cluster is in reset so its flops see the reset.
    assign cluster_clk_en_o    = clk_en_q | rst_busy;
    assign cluster_rst_o       = rst_pulse;
    assign cluster_boot_addr_o = boot_q;

    assign apb_rsp_o.pready  = (state_q == CluCtrlResp);
    assign apb_rsp_o.prdata  = prdata_q;
    assign apb_rsp_o.pslverr = pslverr_q;

    logic unused_bits;
    assign unused_bits = ^{apb_req_i.pprot, apb_req_i.paddr[31:8], boot_offs[1:0],
                           strb_q, rst_req, clk_en_wr};

endmodule

// File: tb/tb_chimera_cluster_ctrl_apb.sv
// Directed bench for chimera_cluster_ctrl_apb: APB transfers with a response
// scoreboard, plus reset-pulse length and output checks.
module tb_chimera_cluster_ctrl_apb;
    import chimera_pkg::*;

    localparam int NC = 5;
    localparam int RC = 16;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    apb_req_t             req;
    apb_resp_t            rsp;
    logic [NC-1:0]        clk_en;
    logic [NC-1:0]        crst;
    logic [NC*32-1:0]     boot;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    bit   mon_en = 1'b0;
    logic prev1 = 1'b0;
    int   rise_c = -1;
    int   fall_c = -1;
    int   clk_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chimera_cluster_ctrl_apb #(
        .NumClusters     (NC),
        .RstCycles       (RC),
        .BootAddrDefault (32'h3000_0000)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .apb_req_i           (req),
        .apb_rsp_o           (rsp),
        .cluster_clk_en_o    (clk_en),
        .cluster_rst_o       (crst),
        .cluster_boot_addr_o (boot)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            if (crst[1] && !prev1) rise_c = cyc;
            if (!crst[1] && prev1) fall_c = cyc;
            if (crst[1] && !clk_en[1]) clk_bad++;
            prev1 = crst[1];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb(input string tag, input logic [7:0] addr, input bit wr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rdata, input bit exp_err, input bit chk_rd);
        exp_t e;
        int   n;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.chk   = chk_rd;
        sb.push_back(e);
        req.paddr   = {24'h0, addr};
        req.pwrite  = wr;
        req.pwdata  = wdata;
        req.pstrb   = strb;
        req.pprot   = 3'b000;
        req.psel    = 1'b1;
        req.penable = 1'b0;
        tick;
        req.penable = 1'b1;
        n = 0;
        do begin
            tick;
            n++;
        end while (!rsp.pready && n < 10);
        check({tag, " wait"}, n, 2);
        e = sb.pop_front();
        check({tag, " pslverr"}, {31'h0, rsp.pslverr}, {31'h0, e.err});
        if (e.chk) check({tag, " prdata"}, rsp.prdata, e.rdata);
        tick;
        req.psel    = 1'b0;
        req.penable = 1'b0;
    endtask

    initial begin
        logic [31:0] strb_exp;
        int n;
        req = '0;
        rst = 1'b1;
        tick;
        tick;
        check("rst cluster_rst", 32'(crst), 32'h1F);
        check("rst pready", {31'h0, rsp.pready}, 32'h0);
        check("rst prdata", rsp.prdata, 32'h0);
        check("rst pslverr", {31'h0, rsp.pslverr}, 32'h0);
        check("rst clk_en", 32'(clk_en), 32'h0);
        rst = 1'b0;
        tick;
        check("post-rst cluster_rst", 32'(crst), 32'h0);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("rst boot%0d", i), boot[i*32+:32], 32'h3000_0000);
        end

        apb("rd boot2", 8'h10, 1'b0, 32'h0, 4'hF, 32'h3000_0000, 1'b0, 1'b1);
        apb("wr clken", 8'h00, 1'b1, 32'h15, 4'hF, 32'h0, 1'b0, 1'b0);
        check("clk_en_o", 32'(clk_en), 32'h15);
        apb("rd clken", 8'h00, 1'b0, 32'h0, 4'hF, 32'h15, 1'b0, 1'b1);
        apb("wr clken upper", 8'h00, 1'b1, 32'hFFFF_FFF5, 4'hF, 32'h0, 1'b0, 1'b0);
        apb("rd clken upper", 8'h00, 1'b0, 32'h0, 4'hF, 32'h15, 1'b0, 1'b1);

        mon_en = 1'b1;
        apb("wr rst1", 8'h04, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0, 1'b0);
        check("rst1 start", 32'(crst), 32'h02);
        check("rst1 clk_en", 32'(clk_en), 32'h17);
        apb("rd busy", 8'h04, 1'b0, 32'h0, 4'hF, 32'h2, 1'b0, 1'b1);
        apb("wr rst1 again", 8'h04, 1'b1, 32'h2, 4'hF, 32'h0, 1'b0, 1'b0);
        apb("rd busy again", 8'h04, 1'b0, 32'h0, 4'hF, 32'h2, 1'b0, 1'b1);
        n = 0;
        while (crst[1] && n < 40) begin
            tick;
            n++;
        end
        tick;
        mon_en = 1'b0;
        check("pulse length", fall_c - rise_c, 16);
        check("clk_en during pulse", clk_bad, 0);
        check("clk_en after pulse", 32'(clk_en), 32'h15);
        apb("rd busy idle", 8'h04, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);

        apb("wr rst0+4", 8'h04, 1'b1, 32'h11, 4'hF, 32'h0, 1'b0, 1'b0);
        check("rst0+4 start", 32'(crst), 32'h11);
        apb("rd busy0+4", 8'h04, 1'b0, 32'h0, 4'hF, 32'h11, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick;
        check("rst0+4 done", 32'(crst), 32'h0);

        apb("rd unmapped", 8'h40, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
        apb("rd misaligned", 8'h06, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
        apb("wr misaligned rst", 8'h06, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b0);
        check("no rst on err", 32'(crst), 32'h0);
        apb("wr past boot", 8'h1C, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0);
        apb("wr misaligned clken", 8'h01, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0);
        check("clk_en after err", 32'(clk_en), 32'h15);

        apb("wr boot4", 8'h18, 1'b1, 32'h4800_0000, 4'hF, 32'h0, 1'b0, 1'b0);
        check("boot4 out", boot[159:128], 32'h4800_0000);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("boot%0d kept", i), boot[i*32+:32], 32'h3000_0000);
        end
        apb("rd boot4", 8'h18, 1'b0, 32'h0, 4'hF, 32'h4800_0000, 1'b0, 1'b1);

`ifdef CHIMERA_CLU_CTRL_STRB_EN
        strb_exp = 32'h3000_BEEF;
`else
        strb_exp = 32'hDEAD_BEEF;
`endif
        apb("wr boot0 strb", 8'h08, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0, 1'b0);
        apb("rd boot0 strb", 8'h08, 1'b0, 32'h0, 4'hF, strb_exp, 1'b0, 1'b1);
        check("boot0 out", boot[31:0], strb_exp);

        req.paddr   = 32'h0C;
        req.pwrite  = 1'b1;
        req.pwdata  = 32'h1234_5678;
        req.pstrb   = 4'hF;
        req.psel    = 1'b1;
        req.penable = 1'b0;
        tick;
        req.penable = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req.psel    = 1'b0;
        req.penable = 1'b0;
        check("abort pready", {31'h0, rsp.pready}, 32'h0);
        tick;
        check("abort pready later", {31'h0, rsp.pready}, 32'h0);
        check("abort cluster_rst", 32'(crst), 32'h0);
        check("abort boot1", boot[63:32], 32'h3000_0000);
        apb("rd boot1 after abort", 8'h0C, 1'b0, 32'h0, 4'hF, 32'h3000_0000, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
